handle_requester: RTL and testbench
===================================

HANDLE_REQUESTER -- requirements
Module: handle_requester

Interface
REQ-001 SHALL have param ADDR_WIDTH, default 16, bus address/data width.
REQ-002 SHALL have param HNDL_WIDTH, default 4, handle id width; offset width OFS_W = ADDR_WIDTH-HNDL_WIDTH-1.
REQ-003 SHALL have port i_clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_req_valid in 1, o_req_ready out 1: request handshake.
REQ-006 SHALL have port i_req_kind  in  2  request kind: 0 ALLOC, 1 FREE, 2 LOAD, 3 STORE.
REQ-007 SHALL have ports i_req_handle in HNDL_WIDTH, i_req_offset in OFS_W, i_req_data in ADDR_WIDTH (ALLOC base or STORE data).
REQ-008 SHALL have ports o_rsp_valid out 1, i_rsp_ready in 1, o_rsp_data out ADDR_WIDTH, o_rsp_error out 1.
REQ-009 SHALL have ports o_op out 3, o_address out ADDR_WIDTH, o_data out ADDR_WIDTH, i_data in ADDR_WIDTH: bus to the handle translator.

Function
REQ-010 SHALL encode o_op as NOP=0, READ=1, WRITE=2; o_op SHALL be registered and each bus op SHALL last exactly one cycle.
REQ-011 SHALL form handle-command addresses as {(HNDL_WIDTH+1) ones, zero fill, id}; normal accesses as {1'b0, handle, offset}.
REQ-012 SHALL sample i_data on the rising edge ending a READ bus cycle (combinational responder).
REQ-013 SHALL implement FSM IDLE, ALLOC_ID, ALLOC_MAP, FREE, ACCESS, RESP.
REQ-014 SHALL assert o_req_ready only in IDLE; acceptance on edge with valid&ready captures all request fields.
REQ-015 ALLOC: IDLE->ALLOC_ID (READ, id=all ones); returned id all ones -> RESP error=1, data=all ones; else ALLOC_MAP (WRITE, id=returned, o_data=base) -> RESP error=0, data=id.
REQ-016 ALLOC with base==0 SHALL go directly IDLE->RESP, error=1, no bus op (zero would mean invalidate).
REQ-017 ALLOC with i_req_handle ignored; FREE with handle all ones SHALL respond error=1, no bus op.
REQ-018 FREE: IDLE->FREE (WRITE, id=handle, o_data=0) -> RESP error=0, data=0.
REQ-019 LOAD/STORE: IDLE->ACCESS (READ or WRITE at normal address, o_data=STORE data) -> RESP; LOAD data=sampled i_data, STORE data=0.
REQ-020 RESP SHALL hold o_rsp_valid/data/error stable until i_rsp_ready, then return to IDLE on that edge.
REQ-021 Latency accept->o_rsp_valid: ALLOC 3 cycles, ALLOC-fail 2, FREE/LOAD/STORE 2, rejected request 1.
REQ-022 o_data SHALL be 0 and o_address 0 whenever o_op is NOP.
REQ-023 Address arithmetic SHALL be pure concatenation, no carry between fields.

Reset
REQ-024 On i_reset, immediately: state IDLE, o_op NOP, o_address 0, o_data 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_error 0; o_req_ready 1 once reset deasserts.
REQ-025 Reset mid-operation SHALL abort the op without completing remaining bus cycles and discard the pending response.

Configuration
REQ-026 Macro HANDLE_REQ_TRACK_EN defined: keep 2^HNDL_WIDTH valid bitmap (set on successful ALLOC, cleared on FREE, cleared on reset); FREE/LOAD/STORE on a clear bit SHALL respond error=1 after 1 cycle with no bus op.
REQ-027 Macro undefined: no bitmap; those requests SHALL be forwarded unchecked.

Structure
REQ-028 Op encodings, request-kind encodings, and ADDR/HNDL width defaults SHALL live in the shared handle package used by the translator.
REQ-029 Single module; no sub-module (bitmap inline under the macro).

Verification (ADDR_WIDTH=16, HNDL_WIDTH=4)
REQ-030 ALLOC base 0x0400, responder returns 0x0003 -> bus READ 0xF80F, then WRITE 0xF803 data 0x0400; rsp data 0x0003 err 0, 3 cycles.
REQ-031 ALLOC, responder returns 0xFFFF -> only READ 0xF80F; rsp err 1, data 0xFFFF.
REQ-032 LOAD handle 3 offset 0x012, i_data 0xBEEF -> READ 0x1812; rsp data 0xBEEF; STORE same with data 0x55AA -> WRITE 0x1812 data 0x55AA.
REQ-033 FREE handle 3 -> WRITE 0xF803 data 0x0000; with HANDLE_REQ_TRACK_EN subsequent LOAD handle 3 -> err 1, no bus op.
REQ-034 i_rsp_ready held low 5 cycles -> response stable, o_req_ready 0; ALLOC base 0 -> err 1, no bus op.
REQ-035 i_reset asserted during ALLOC_MAP cycle -> o_op NOP same cycle, no response, next request accepted normally.

Source files
------------

// File: rtl/handle_pkg.sv
// Shared definitions for the handle requester and the handle translator it drives:
// bus op codes, request kinds and default widths.
package handle_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int HNDL_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2
    } bus_op_e;

    typedef enum logic [1:0] {
        KIND_ALLOC = 2'd0,
        KIND_FREE  = 2'd1,
        KIND_LOAD  = 2'd2,
        KIND_STORE = 2'd3
    } req_kind_e;

endpackage

// File: rtl/handle_requester.sv
// Handle requester: turns ALLOC/FREE/LOAD/STORE requests into one-cycle bus
// operations towards the handle translator and returns a single response.
// Optional feature: define HANDLE_REQ_TRACK_EN to keep a per-handle valid bitmap
// and reject FREE/LOAD/STORE on handles that are not currently allocated.
module handle_requester
    import handle_pkg::*;
#(
    parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter  int HNDL_WIDTH = HNDL_WIDTH_DEF,
    localparam int OFS_W      = ADDR_WIDTH - HNDL_WIDTH - 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_kind,
    input  logic [HNDL_WIDTH-1:0] i_req_handle,
    input  logic [OFS_W-1:0]      i_req_offset,
    input  logic [ADDR_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [ADDR_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_error,
    output logic [2:0]            o_op,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [ADDR_WIDTH-1:0] o_data,
    input  logic [ADDR_WIDTH-1:0] i_data
);

    // Width of the zero gap between the command prefix and the id.
    localparam int ZERO_W = ADDR_WIDTH - 2 * HNDL_WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC_ID,
        S_ALLOC_MAP,
        S_FREE,
        S_ACCESS,
        S_RESP
    } state_e;

    // Handle-command address: prefix of ones marks a translator command, low bits carry the id.
    function automatic logic [ADDR_WIDTH-1:0] cmd_addr(input logic [HNDL_WIDTH-1:0] id);
        return {{(HNDL_WIDTH + 1){1'b1}}, {ZERO_W{1'b0}}, id};
    endfunction

    // Normal access address: plain field concatenation, no carry between fields.
    function automatic logic [ADDR_WIDTH-1:0] norm_addr(input logic [HNDL_WIDTH-1:0] handle,
                                                        input logic [OFS_W-1:0]      offset);
        return {1'b0, handle, offset};
    endfunction

    state_e                state_q, state_d;
    req_kind_e             kind_q, kind_d;
    logic [ADDR_WIDTH-1:0] wdata_q, wdata_d;
    logic [HNDL_WIDTH-1:0] id_q, id_d;
    bus_op_e               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] odata_q, odata_d;
    logic [ADDR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  hndl_ok;
    req_kind_e             req_kind;

    assign req_kind = req_kind_e'(i_req_kind);

`ifdef HANDLE_REQ_TRACK_EN
    logic [(2**HNDL_WIDTH)-1:0] valid_q, valid_d;
    logic [HNDL_WIDTH-1:0]      handle_q, handle_d;

    assign hndl_ok = valid_q[i_req_handle];

    // Bitmap update: set when an ALLOC mapping completes, clear when a FREE completes.
    always_comb begin
        valid_d = valid_q;
        if (state_q == S_ALLOC_MAP) begin
            valid_d[id_q] = 1'b1;
        end else if (state_q == S_FREE) begin
            valid_d[handle_q] = 1'b0;
        end
    end

    // Bitmap and freed-handle registers.
    // NOTE: the bitmap is reset like any control register; a stale bit after reset
    // would let requests through on handles the translator no longer holds.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            valid_q  <= '0;
            handle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            handle_q <= handle_d;
        end
    end

    // Remember which handle a FREE targets so its bit can be cleared on completion.
    always_comb begin
        handle_d = handle_q;
        if (state_q == S_IDLE && i_req_valid) begin
            handle_d = i_req_handle;
        end
    end
`else
    assign hndl_ok = 1'b1;
`endif

    // Next-state and registered-output logic for the request FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        kind_d     = kind_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        op_d       = OP_NOP;
        addr_d     = '0;
        odata_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    kind_d     = req_kind;
                    wdata_d    = i_req_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    unique case (req_kind)
                        KIND_ALLOC: begin
                            // A zero base would read as an invalidate, so refuse it outright.
                            if (i_req_data == '0) begin
                                state_d   = S_RESP;
                                rsp_err_d = 1'b1;
                            end else begin
                                state_d = S_ALLOC_ID;
                                op_d    = OP_READ;
                                addr_d  = cmd_addr('1);
                            end
                        end
                        KIND_FREE: begin
                            if (i_req_handle == '1 || !hndl_ok) begin
                                state_d   = S_RESP;
                                rsp_err_d = 1'b1;
                            end else begin
                                state_d = S_FREE;
                                op_d    = OP_WRITE;
                                addr_d  = cmd_addr(i_req_handle);
                            end
                        end
                        KIND_LOAD, KIND_STORE: begin
                            if (!hndl_ok) begin
                                state_d   = S_RESP;
                                rsp_err_d = 1'b1;
                            end else begin
                                state_d = S_ACCESS;
                                op_d    = (req_kind == KIND_LOAD) ? OP_READ : OP_WRITE;
                                addr_d  = norm_addr(i_req_handle, i_req_offset);
                                odata_d = (req_kind == KIND_STORE) ? i_req_data : '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ALLOC_ID: begin
                // Translator returns a free id, or all ones when none is left.
                id_d = i_data[HNDL_WIDTH-1:0];
                if (i_data[HNDL_WIDTH-1:0] == '1) begin
                    state_d    = S_RESP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '1;
                end else begin
                    state_d = S_ALLOC_MAP;
                    op_d    = OP_WRITE;
                    addr_d  = cmd_addr(i_data[HNDL_WIDTH-1:0]);
                    odata_d = wdata_q;
                end
            end
            S_ALLOC_MAP: begin
                state_d    = S_RESP;
                rsp_data_d = ADDR_WIDTH'(id_q);
            end
            S_FREE: begin
                state_d = S_RESP;
            end
            S_ACCESS: begin
                state_d    = S_RESP;
                rsp_data_d = (kind_q == KIND_LOAD) ? i_data : '0;
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d    = S_IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, request context, bus and response registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            kind_q     <= KIND_ALLOC;
            wdata_q    <= '0;
            id_q       <= '0;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            odata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            kind_q     <= kind_d;
            wdata_q    <= wdata_d;
            id_q       <= id_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            odata_q    <= odata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE) && !i_reset;
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_error = rsp_err_q;
    assign o_op        = op_q;
    assign o_address   = addr_q;
    assign o_data      = odata_q;

endmodule

// File: tb/tb_handle_requester.sv
// Self-checking bench for handle_requester (ADDR_WIDTH=16, HNDL_WIDTH=4).
// A behavioural model predicts bus ops, response and latency per request;
// honours HANDLE_REQ_TRACK_EN the same way the design does.
module tb_handle_requester;

    localparam int AW = 16;
    localparam int HW = 4;
    localparam int OW = AW - HW - 1;
    localparam int OPR = 1;
    localparam int OPW = 2;
    localparam logic [AW-1:0] CMD_BASE = AW'(((2 ** (HW + 1)) - 1) << (AW - HW - 1));

    logic          clk;
    logic          i_reset;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [1:0]    i_req_kind;
    logic [HW-1:0] i_req_handle;
    logic [OW-1:0] i_req_offset;
    logic [AW-1:0] i_req_data;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [AW-1:0] o_rsp_data;
    logic          o_rsp_error;
    logic [2:0]    o_op;
    logic [AW-1:0] o_address;
    logic [AW-1:0] o_data;
    logic [AW-1:0] i_data;
    logic [AW-1:0] rd_val;

    int checks = 0;
    int errors = 0;

    handle_requester dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_kind   (i_req_kind),
        .i_req_handle (i_req_handle),
        .i_req_offset (i_req_offset),
        .i_req_data   (i_req_data),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_error  (o_rsp_error),
        .o_op         (o_op),
        .o_address    (o_address),
        .o_data       (o_data),
        .i_data       (i_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational responder: only meaningful during a READ cycle.
    assign i_data = (o_op == 3'(OPR)) ? rd_val : 16'hDEAD;

    typedef struct {
        int          op;
        logic [AW-1:0] addr;
        logic [AW-1:0] data;
    } bus_t;

    bus_t bus_q[$];
    bit   nop_bad;
    bit   valid_m[2**HW];

    // Bus monitor: record every non-NOP cycle, flag dirty NOP cycles.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_op != 3'd0) begin
                bus_q.push_back('{int'(o_op), o_address, o_data});
            end else if (o_address != '0 || o_data != '0) begin
                nop_bad = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit track_en();
`ifdef HANDLE_REQ_TRACK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One request end to end: model prediction, drive, observe, hold, release.
    task automatic run_req(input int kind, input int handle, input int offset,
                           input logic [AW-1:0] data, input logic [AW-1:0] ret, input int hold);
        bus_t          exp_ops[$];
        int            exp_lat;
        logic [AW-1:0] exp_rsp;
        logic          exp_err;
        bit            chk_data;
        int            lat;
        logic [AW-1:0] snap;
        bit            rejected;

        exp_ops.delete();
        exp_err  = 1'b0;
        exp_rsp  = '0;
        chk_data = 1'b1;
        rejected = 1'b0;

        case (kind)
            0: begin
                if (data == 0) begin
                    rejected = 1'b1;
                end else begin
                    exp_ops.push_back('{OPR, CMD_BASE | AW'(2 ** HW - 1), '0});
                    if (ret == 16'hFFFF) begin
                        exp_lat = 2;
                        exp_err = 1'b1;
                        exp_rsp = 16'hFFFF;
                    end else begin
                        exp_ops.push_back('{OPW, CMD_BASE | ret, data});
                        exp_lat = 3;
                        exp_rsp = ret;
                        valid_m[ret[HW-1:0]] = 1'b1;
                    end
                end
            end
            1: begin
                if (handle == 2 ** HW - 1 || (track_en() && !valid_m[handle])) begin
                    rejected = 1'b1;
                end else begin
                    exp_ops.push_back('{OPW, CMD_BASE | AW'(handle), '0});
                    exp_lat = 2;
                    valid_m[handle] = 1'b0;
                end
            end
            default: begin
                if (track_en() && !valid_m[handle]) begin
                    rejected = 1'b1;
                end else begin
                    exp_ops.push_back('{(kind == 2) ? OPR : OPW,
                                        AW'((handle << OW) | offset), data});
                    exp_lat = 2;
                    exp_rsp = (kind == 2) ? ret : '0;
                end
            end
        endcase
        if (rejected) begin
            exp_lat  = 1;
            exp_err  = 1'b1;
            chk_data = 1'b0;
        end

        @(negedge clk);
        check("req_ready_idle", 32'(o_req_ready), 32'd1);
        bus_q.delete();
        nop_bad      = 1'b0;
        rd_val       = ret;
        i_req_kind   = 2'(kind);
        i_req_handle = HW'(handle);
        i_req_offset = OW'(offset);
        i_req_data   = data;
        i_req_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_req_valid  = 1'b0;
        i_req_data   = AW'($urandom);
        i_req_offset = OW'($urandom);
        i_req_handle = HW'($urandom);

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_rsp_valid && lat < 20);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_error", 32'(o_rsp_error), 32'(exp_err));
        if (chk_data) check("rsp_data", 32'(o_rsp_data), 32'(exp_rsp));
        check("bus_count", 32'(bus_q.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < bus_q.size(); i++) begin
            check("bus_op", 32'(bus_q[i].op), 32'(exp_ops[i].op));
            check("bus_addr", 32'(bus_q[i].addr), 32'(exp_ops[i].addr));
            if (exp_ops[i].op == OPW) check("bus_wdata", 32'(bus_q[i].data), 32'(exp_ops[i].data));
        end
        check("nop_clean", 32'(nop_bad), 32'd0);

        snap = chk_data ? exp_rsp : o_rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_hold", {13'd0, o_rsp_valid, o_rsp_error, o_req_ready, o_rsp_data},
                  {13'd0, 1'b1, exp_err, 1'b0, snap});
        end

        @(negedge clk);
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b0;
        check("rsp_release", {30'd0, o_rsp_valid, o_req_ready}, 32'b01);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2 ** HW; i++) valid_m[i] = 1'b0;
    endtask

    initial begin
        int k, h, lat_guard;
        logic [AW-1:0] base, ret;

        reset_model();
        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_kind   = '0;
        i_req_handle = '0;
        i_req_offset = '0;
        i_req_data   = '0;
        i_rsp_ready  = 1'b0;
        rd_val       = '0;
        nop_bad      = 1'b0;
        #1;
        check("rst_op", 32'(o_op), 32'd0);
        check("rst_addr_data", {o_address, o_data}, 32'd0);
        check("rst_rsp", {15'd0, o_rsp_valid, o_rsp_error, o_rsp_data}, 32'd0);
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(o_req_ready), 32'd1);

        // Directed cases from the requirements.
        run_req(0, 9, 0, 16'h0400, 16'h0003, 0);      // ALLOC ok -> id 3
        run_req(0, 0, 0, 16'h0800, 16'hFFFF, 0);      // ALLOC, table full
        run_req(2, 3, 12'h012, 16'h0000, 16'hBEEF, 5); // LOAD, held response
        run_req(3, 3, 12'h012, 16'h55AA, 16'h1111, 1); // STORE
        run_req(0, 0, 0, 16'h0000, 16'h0004, 2);      // ALLOC base 0
        run_req(1, 3, 0, 16'h0000, 16'h0000, 0);      // FREE 3
        run_req(2, 3, 12'h012, 16'h0000, 16'hCAFE, 0); // LOAD after FREE
        run_req(1, 15, 0, 16'h0000, 16'h0000, 0);     // FREE all-ones handle

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 3));
            h = int'($urandom_range(0, 2 ** HW - 1));
            base = ($urandom_range(0, 7) == 0) ? 16'h0000 : AW'($urandom);
            ret  = ($urandom_range(0, 5) == 0) ? 16'hFFFF
                 : ((k == 0) ? AW'($urandom_range(0, 2 ** HW - 2)) : AW'($urandom));
            run_req(k, h, int'($urandom_range(0, 2 ** OW - 1)), base, ret,
                    int'($urandom_range(0, 3)));
        end

        // Reset during the mapping WRITE of an ALLOC.
        @(negedge clk);
        rd_val       = 16'h0005;
        i_req_kind   = 2'd0;
        i_req_data   = 16'h1234;
        i_req_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_write", 32'(o_op), 32'(OPW));
        i_reset = 1'b1;
        #1;
        check("reset_abort_op", 32'(o_op), 32'd0);
        check("reset_abort_bus", {o_address, o_data}, 32'd0);
        check("reset_abort_rsp", {31'd0, o_rsp_valid}, 32'd0);
        reset_model();
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        bus_q.delete();
        lat_guard = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_rsp_valid) lat_guard++;
        end
        check("no_rsp_after_abort", 32'(lat_guard), 32'd0);
        check("no_bus_after_abort", 32'(bus_q.size()), 32'd0);
        run_req(0, 0, 0, 16'h0400, 16'h0003, 0);
        run_req(2, 3, 12'h7FF, 16'h0000, 16'h0F0F, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
